// File: rtl/sort4_ctrl.sv
// -----------------------------------------------------------------------------
// sort4_ctrl
//
// Loads a block of DEPTH bytes through a valid/ready input stream. It then
// sorts the block in place with a bubble sort that does one compare-and-swap
// per clock through a single shared unsigned 8-bit comparator. Finally it
// returns the bytes in ascending order through a valid/ready output stream.
//
// Parameters
//   DEPTH       bytes per block (2..8)
//   CW          width of swap_count
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   in_valid    in_data holds a byte to load
//   in_data     operand byte
//   in_ready    block accepts a byte this cycle (LOAD only)
//   out_valid   out_data holds a sorted byte (OUT only)
//   out_data    sorted byte, ascending order
//   out_ready   consumer accepts out_data
//   busy        high while sorting or presenting results
//   done        one-cycle pulse on the final output handshake
//   swap_count  number of swaps performed by the last sort
// -----------------------------------------------------------------------------

// Unsigned magnitude comparator: y_o = (a_i > b_i).
module compare_8b (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic       y_o
);
    assign y_o = (a_i > b_i);
endmodule

module sort4_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] swap_count
);

    localparam int IW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_J    = IW'(DEPTH - 2);
    localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [IW-1:0] ld_idx_q, ld_idx_d;
    logic [IW-1:0] j_q, j_d;
    logic [IW-1:0] pass_q, pass_d;
    logic [IW-1:0] o_idx_q, o_idx_d;
    logic [CW-1:0] swap_q, swap_d;

    logic [IW-1:0] j_nxt;
    logic [7:0]    cmp_a;
    logic [7:0]    cmp_b;
    logic          cmp_y;

    // j never exceeds DEPTH-2, so j+1 always addresses a valid entry.
    assign j_nxt = j_q + IW'(1);
    assign cmp_a = mem_q[j_q];
    assign cmp_b = mem_q[j_nxt];

    compare_8b u_cmp (
        .a_i (cmp_a),
        .b_i (cmp_b),
        .y_o (cmp_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            ld_idx_q <= '0;
            j_q      <= '0;
            pass_q   <= '0;
            o_idx_q  <= '0;
            swap_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            ld_idx_q <= ld_idx_d;
            j_q      <= j_d;
            pass_q   <= pass_d;
            o_idx_q  <= o_idx_d;
            swap_q   <= swap_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_idx_d  = ld_idx_q;
        j_d       = j_q;
        pass_d    = pass_q;
        o_idx_d   = o_idx_q;
        swap_d    = swap_q;
        mem_d     = mem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        done      = 1'b0;

        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_d[ld_idx_q] = in_data;
                    // A new block starts: the previous result is retired.
                    if (ld_idx_q == '0) begin
                        swap_d = '0;
                    end
                    if (ld_idx_q == LAST_IDX) begin
                        ld_idx_d = '0;
                        j_d      = '0;
                        pass_d   = '0;
                        state_d  = SORT;
                    end else begin
                        ld_idx_d = ld_idx_q + IW'(1);
                    end
                end
            end

            SORT: begin
                // Strict greater-than keeps equal bytes in place (stable).
                if (cmp_y) begin
                    mem_d[j_q]   = mem_q[j_nxt];
                    mem_d[j_nxt] = mem_q[j_q];
                    swap_d       = swap_q + CW'(1);
                end
                // Fixed (DEPTH-1) passes of (DEPTH-1) compares; no early exit.
                if (j_q == LAST_J) begin
                    j_d = '0;
                    if (pass_q == LAST_PASS) begin
                        pass_d  = '0;
                        state_d = OUT;
                    end else begin
                        pass_d = pass_q + IW'(1);
                    end
                end else begin
                    j_d = j_nxt;
                end
            end

            OUT: begin
                out_valid = 1'b1;
                out_data  = mem_q[o_idx_q];
                if (out_ready) begin
                    if (o_idx_q == LAST_IDX) begin
                        done    = 1'b1;
                        o_idx_d = '0;
                        state_d = LOAD;
                    end else begin
                        o_idx_d = o_idx_q + IW'(1);
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign busy       = (state_q == SORT) | (state_q == OUT);
    assign swap_count = swap_q;

endmodule

// File: tb/tb_sort4_ctrl.sv
module tb_sort4_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [5:0] swap_count;

    int checks = 0;
    int errors = 0;

    sort4_ctrl #(.DEPTH(4), .CW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din  [4];
        logic [7:0] dout [4];
        int         swaps;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] a0, a1, a2, a3,
                                input logic [7:0] e0, e1, e2, e3, input int s);
        vec_t v;
        v.din[0] = a0;  v.din[1] = a1;  v.din[2] = a2;  v.din[3] = a3;
        v.dout[0] = e0; v.dout[1] = e1; v.dout[2] = e2; v.dout[3] = e3;
        v.swaps = s;
        return v;
    endfunction

    // Loads four bytes back to back; returns on the negedge after the last accept.
    task automatic load_block(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v.din[i];
            chk("in_ready_load", in_ready, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Counts edges from the accepting edge (counted as 1) up to the first out_valid.
    task automatic wait_out(output int edges);
        edges = 1;
        while (!out_valid && edges < 40) begin
            chk("busy_sort", busy, 1'b1);
            chk("in_ready_sort", in_ready, 1'b0);
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int edges;
        chk({tag, "_idle_busy"}, busy, 1'b0);
        load_block(v);
        wait_out(edges);
        chk({tag, "_latency"}, edges, 10);
        chk({tag, "_swaps"}, swap_count, v.swaps);
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            chk({tag, "_out_valid"}, out_valid, 1'b1);
            chk({tag, "_out_data"}, out_data, v.dout[i]);
            chk({tag, "_done"}, done, (i == 3));
            chk({tag, "_busy_out"}, busy, 1'b1);
            chk({tag, "_in_ready_out"}, in_ready, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk({tag, "_back_to_load"}, in_ready, 1'b1);
        chk({tag, "_valid_low"}, out_valid, 1'b0);
        chk({tag, "_done_low"}, done, 1'b0);
        chk({tag, "_swaps_hold"}, swap_count, v.swaps);
    endtask

    initial begin
        int edges;
        vec_t bp;
        vec_t rv;

        vecs[0] = mk(8'h03, 8'h01, 8'h04, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 3);
        vecs[1] = mk(8'h10, 8'h20, 8'h30, 8'h40, 8'h10, 8'h20, 8'h30, 8'h40, 0);
        vecs[2] = mk(8'hFF, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h80, 8'hFF, 6);
        vecs[3] = mk(8'h05, 8'h05, 8'h02, 8'h05, 8'h02, 8'h05, 8'h05, 8'h05, 2);
        vecs[4] = mk(8'h09, 8'h08, 8'h07, 8'h06, 8'h06, 8'h07, 8'h08, 8'h09, 6);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_swaps", swap_count, 6'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            run_vector(vecs[k], $sformatf("vec%0d", k));
        end

        // Backpressure at o_idx=1 with in_valid held high through SORT and OUT.
        bp = mk(8'h40, 8'h30, 8'h20, 8'h10, 8'h10, 8'h20, 8'h30, 8'h40, 6);
        load_block(bp);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        wait_out(edges);
        chk("bp_latency", edges, 10);
        chk("bp_swaps", swap_count, 6);
        out_ready = 1'b1;
        chk("bp_out0", out_data, 8'h10);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("bp_stall_valid", out_valid, 1'b1);
            chk("bp_stall_data", out_data, 8'h20);
            chk("bp_stall_done", done, 1'b0);
            chk("bp_stall_in_ready", in_ready, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            if (i == 3) in_valid = 1'b0;
            chk("bp_out_data", out_data, bp.dout[i]);
            chk("bp_done", done, (i == 3));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_back_to_load", in_ready, 1'b1);

        // Reset while presenting results (swap_count nonzero at that point).
        load_block(vecs[2]);
        wait_out(edges);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_in_ready", in_ready, 1'b1);
        chk("rst_out_out_valid", out_valid, 1'b0);
        chk("rst_out_swaps", swap_count, 6'd0);
        chk("rst_out_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset between edges after two bytes of a block are loaded.
        rv = vecs[0];
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = rv.din[i];
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_swaps", swap_count, 6'd0);
        chk("rst_mid_out_data", out_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_vector(vecs[4], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/sort4_ctrl.md
Name: sort4_ctrl

Overview:
- Sequencer that shares one compare_8b instance across a DEPTH-entry byte register file.
- compare_8b function: y=1 iff a>b, unsigned.
- Performs an in-place bubble sort, one compare-and-swap per clock.
- Loads operands through a valid/ready input stream; returns them in ascending order through a valid/ready output stream. Reusable front end for min/max and ranking logic.

Parameters:
- DEPTH, 4, number of bytes per block; legal range 2..8.
- CW, 6, width of swap_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a byte to load.
- in_data  input  8  operand byte.
- in_ready  output  1  block accepts a byte this cycle.
- out_valid  output  1  out_data holds a sorted byte.
- out_data  output  8  sorted byte, ascending order.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in SORT and OUT.
- done  output  1  one-cycle pulse on the final output handshake.
- swap_count  output  CW  number of swaps performed by the last sort.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (clk, rst).
- rst asserted, at any time including mid-operation:
  - state=LOAD; all mem entries, load index, compare index, pass counter, out index and swap_count cleared to 0.
  - Any partially loaded block is discarded.
  - Outputs while in reset: in_ready=1, out_valid=0, out_data=8'h00, busy=0, done=0, swap_count=0.
- States: LOAD, SORT, OUT.
- LOAD:
  - in_ready=1.
  - Handshake (in_valid & in_ready) at an edge writes in_data to mem[ld_idx] and increments ld_idx.
  - First accepted byte of a block clears swap_count.
  - Accepting byte DEPTH-1 moves to SORT and resets j=0, pass=0.
- SORT:
  - in_ready=0; in_valid is ignored.
  - Each cycle: comparator a=mem[j], b=mem[j+1].
  - If y=1, swap the two entries and increment swap_count. Equal values are not swapped (stable).
  - j runs 0..DEPTH-2. On wrap, j returns to 0 and pass increments.
  - After pass DEPTH-2 completes, move to OUT.
  - Fixed length: no early exit on an already-sorted block.
  - SORT lasts exactly (DEPTH-1)^2 cycles (9 for DEPTH=4). out_valid first rises (DEPTH-1)^2+1 edges after the edge that accepts the last input byte.
- OUT:
  - out_valid=1; out_data=mem[o_idx], combinational from registers.
  - Handshake advances o_idx.
  - Without a handshake, out_data and o_idx hold (backpressure, no limit on stall length).
  - Handshake at o_idx=DEPTH-1: done=1 for that cycle, o_idx clears, next state LOAD.
  - in_ready is never asserted in the same cycle as out_valid.
- swap_count holds its value through OUT and LOAD until the first byte of the next block is accepted. It never overflows, since the maximum is DEPTH(DEPTH-1)/2 = 28 < 2^CW.
- busy = (state==SORT) | (state==OUT).
- All comparisons are unsigned 8-bit. No arithmetic on data; data width is fixed at 8.

Test Plan:
1. DEPTH=4, load 03,01,04,02 → out 01,02,03,04; swap_count=3; done pulses exactly once, on the 4th output handshake.
2. Load 10,20,30,40 → swap_count=0; out_valid rises exactly 10 edges after the 4th input accept; busy=1 throughout SORT and OUT.
3. Load FF,80,7F,00 → out 00,7F,80,FF (unsigned, 80>7F); swap_count=6.
4. Load 05,05,02,05 → out 02,05,05,05; swap_count=2.
5. Backpressure and input blocking:
   - out_ready low for 3 cycles while at o_idx=1 → out_data stays at the 2nd sorted value; no skip or duplicate.
   - in_valid held high during SORT/OUT → in_ready=0, mem unchanged.
6. Reset mid-operation:
   - Assert rst between clock edges after 2 bytes are loaded → in_ready=1, out_valid=0, swap_count=0 immediately.
   - Then load 09,08,07,06 → out 06,07,08,09; swap_count=6.
